uart_byte_receiver: RTL and testbench

//   Serial-to-byte UART receive front end (8N1, LSB first, idle-high line).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_byte_receiver.sv | 144 ++++++++++++++
 tb/tb_uart_byte_receiver.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
// The transmitter imports the same default so both ends agree on baud rate.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   localparam int DEFAULT_CLK_PER_HALF_BIT = 434;
   localparam int UART_DATA_BITS           = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous UART_RX pin.
// Flops reset to 1 so an idle line never looks like a start bit after reset.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] chain_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chain_reg <= '1;
      end else begin
         chain_reg <= {chain_reg[SYNC_STAGES-2:0], din};
      end
   end

   assign dout = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receive front end: start-bit detect, mid-bit sampling, one byte
// per frame with a single-cycle valid_rec strobe or ferr on a bad stop bit.
module uart_byte_receiver
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = DEFAULT_CLK_PER_HALF_BIT,
   parameter int SYNC_STAGES      = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       UART_RX,
   output logic       valid_rec,
   output logic [7:0] data_rec,
   output logic       ferr
);

   localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
   localparam int CNT_W      = $clog2(BIT_CYCLES);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             rxs;

   uart_rx_state_t   state_reg,   state_next;
   logic [CNT_W-1:0] cnt_reg,     cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg,   shift_next;
   logic [7:0]       data_reg,    data_next;
   logic             valid_reg,   valid_next;
   logic             ferr_reg,    ferr_next;

   logic             half_done;
   logic             bit_done;

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .din  (UART_RX),
      .dout (rxs)
   );

   assign half_done = (cnt_reg == HALF_LAST);
   assign bit_done  = (cnt_reg == BIT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         ferr_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         ferr_reg    <= ferr_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg + CNT_ONE;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      data_next    = data_reg;
      valid_next   = 1'b0;
      ferr_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (!rxs) begin
               state_next = START;
            end
         end

         START: begin
            // A low level that is gone by mid start bit is treated as noise.
            if (half_done) begin
               cnt_next = '0;
               if (!rxs) begin
                  state_next   = DATA;
                  bit_idx_next = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         DATA: begin
            if (bit_done) begin
               cnt_next   = '0;
               shift_next = {rxs, shift_reg[7:1]};
               if (bit_idx_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end
         end

         STOP: begin
            // Deciding at mid-stop leaves half a bit to re-arm for the next start.
            if (bit_done) begin
               cnt_next = '0;
               if (rxs) begin
                  data_next  = shift_reg;
                  valid_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = BREAK;
               end
            end
         end

         BREAK: begin
            cnt_next = '0;
            if (rxs) begin
               state_next = IDLE;
            end
         end

         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign valid_rec = valid_reg;
   assign data_rec  = data_reg;
   assign ferr      = ferr_reg;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: two H=434 receivers for directed frames and an
// H=8 receiver for skewed/random traffic, all checked against a frame-level model.
module tb_uart_byte_receiver;

   localparam int H_A     = 434;
   localparam int H_C     = 8;
   localparam int SYNC    = 2;
   localparam int CLK_T   = 100;
   localparam int P_A     = 2 * H_A * CLK_T;
   localparam int P_C     = 2 * H_C * CLK_T;
   localparam int QD      = 256;
   localparam int K_VALID = 1;
   localparam int K_FERR  = 2;

   logic       clk = 1'b0;
   logic       rstn_v [3];
   logic       rx_v   [3];
   logic       vld    [3];
   logic       fe     [3];
   logic [7:0] dat    [3];

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   // Expected strobes per receiver: kind, byte and the cycle window it must land in.
   int         exp_kind [3][QD];
   logic [7:0] exp_data [3][QD];
   int         exp_lo   [3][QD];
   int         exp_hi   [3][QD];
   int         qh [3];
   int         qt [3];
   logic [7:0] last_byte [3];
   int         valid_cnt [3];
   int         ferr_cnt  [3];
   int         last_strobe_cyc [3];
   int         hv [3] = '{H_A, H_A, H_C};

   uart_byte_receiver #(.CLK_PER_HALF_BIT(H_A), .SYNC_STAGES(SYNC)) dut_a (
      .clk(clk), .rstn(rstn_v[0]), .UART_RX(rx_v[0]),
      .valid_rec(vld[0]), .data_rec(dat[0]), .ferr(fe[0]));

   uart_byte_receiver #(.CLK_PER_HALF_BIT(H_A), .SYNC_STAGES(SYNC)) dut_b (
      .clk(clk), .rstn(rstn_v[1]), .UART_RX(rx_v[1]),
      .valid_rec(vld[1]), .data_rec(dat[1]), .ferr(fe[1]));

   uart_byte_receiver #(.CLK_PER_HALF_BIT(H_C), .SYNC_STAGES(SYNC)) dut_c (
      .clk(clk), .rstn(rstn_v[2]), .UART_RX(rx_v[2]),
      .valid_rec(vld[2]), .data_rec(dat[2]), .ferr(fe[2]));

   always #(CLK_T / 2) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int inst, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s inst=%0d cyc=%0d: got %0d, expected %0d", name, inst, cyc, act, expv);
      end
   endtask

   task automatic chk_range(input string name, input int inst, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s inst=%0d: got %0d, expected %0d..%0d", name, inst, act, lo, hi);
      end
   endtask

   task automatic push_exp(input int i, input int kind, input logic [7:0] b, input int c0);
      int k;
      k = qt[i] % QD;
      exp_kind[i][k] = kind;
      exp_data[i][k] = b;
      exp_lo[i][k]   = c0 + SYNC + 19 * hv[i] - 2;
      exp_hi[i][k]   = c0 + SYNC + 19 * hv[i] + 2;
      qt[i]++;
   endtask

   task automatic model_reset(input int i);
      qh[i]        = qt[i];
      last_byte[i] = 8'h00;
   endtask

   // Drive one 8N1 frame, LSB first; the line is left at the stop-bit level.
   task automatic send_frame(input int i, input logic [7:0] b, input logic stop,
                             input int per, input bit want_strobe);
      if (want_strobe) push_exp(i, stop ? K_VALID : K_FERR, b, cyc);
      rx_v[i] = 1'b0;
      #(per);
      for (int k = 0; k < 8; k++) begin
         rx_v[i] = b[k];
         #(per);
      end
      rx_v[i] = stop;
      #(per);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int k;
         if (rstn_v[i]) begin
            k = qh[i] % QD;
            if (vld[i] || fe[i]) begin
               chk("valid_ferr_exclusive", i, int'(vld[i] & fe[i]), 0);
               if (qh[i] == qt[i]) begin
                  chk("unexpected_strobe", i, 1, 0);
                  if (vld[i]) last_byte[i] = dat[i];
               end else begin
                  chk("strobe_kind", i, vld[i] ? K_VALID : K_FERR, exp_kind[i][k]);
                  chk_range("strobe_cycle", i, cyc, exp_lo[i][k], exp_hi[i][k]);
                  if (vld[i]) begin
                     chk("strobe_data", i, int'(dat[i]), int'(exp_data[i][k]));
                     last_byte[i] = (exp_kind[i][k] == K_VALID) ? exp_data[i][k] : dat[i];
                  end
                  qh[i]++;
               end
               if (vld[i]) valid_cnt[i]++;
               else        ferr_cnt[i]++;
               last_strobe_cyc[i] = cyc;
            end else if (qh[i] != qt[i] && exp_hi[i][k] < cyc) begin
               chk("missing_strobe", i, 0, 1);
               qh[i]++;
            end
            chk("data_rec_hold", i, int'(dat[i]), int'(last_byte[i]));
         end
      end
   end

   task automatic seq_a();
      int c0;
      int v0;
      int f0;
      int t [3];
      logic [7:0] bb [3];

      // Single frame: value, count and latency from the start edge.
      v0 = valid_cnt[0];
      f0 = ferr_cnt[0];
      c0 = cyc;
      send_frame(0, 8'hA5, 1'b1, P_A, 1'b1);
      #(P_A);
      chk("t1_valid_count", 0, valid_cnt[0] - v0, 1);
      chk("t1_ferr_count", 0, ferr_cnt[0] - f0, 0);
      chk("t1_data", 0, int'(dat[0]), 8'hA5);
      chk_range("t1_latency", 0, last_strobe_cyc[0] - c0, 19 * H_A, 19 * H_A + 4);

      // Back-to-back frames with no idle gap.
      bb[0] = 8'h00;
      bb[1] = 8'hFF;
      bb[2] = 8'h55;
      v0 = valid_cnt[0];
      for (int n = 0; n < 3; n++) begin
         send_frame(0, bb[n], 1'b1, P_A, 1'b1);
         t[n] = last_strobe_cyc[0];
         chk("t2_data", 0, int'(dat[0]), int'(bb[n]));
      end
      chk_range("t2_spacing01", 0, t[1] - t[0], 20 * H_A - 2, 20 * H_A + 2);
      chk_range("t2_spacing12", 0, t[2] - t[1], 20 * H_A - 2, 20 * H_A + 2);
      #(P_A);
      chk("t2_valid_count", 0, valid_cnt[0] - v0, 3);

      // Short low glitch must be rejected, then a clean frame.
      v0 = valid_cnt[0];
      f0 = ferr_cnt[0];
      rx_v[0] = 1'b0;
      #(100 * CLK_T);
      rx_v[0] = 1'b1;
      #(P_A);
      chk("t3_glitch_valid", 0, valid_cnt[0] - v0, 0);
      chk("t3_glitch_ferr", 0, ferr_cnt[0] - f0, 0);
      send_frame(0, 8'h3C, 1'b1, P_A, 1'b1);
      #(P_A);
      chk("t3_data", 0, int'(dat[0]), 8'h3C);
      chk("t3_valid_count", 0, valid_cnt[0] - v0, 1);
   endtask

   task automatic seq_b();
      int v0;
      int f0;

      send_frame(1, 8'h42, 1'b1, P_A, 1'b1);
      #(P_A);
      chk("t4_pre_data", 1, int'(dat[1]), 8'h42);

      // Bad stop bit followed by a long break.
      v0 = valid_cnt[1];
      f0 = ferr_cnt[1];
      send_frame(1, 8'h81, 1'b0, P_A, 1'b1);
      #(30 * H_A * CLK_T);
      rx_v[1] = 1'b1;
      #(P_A);
      chk("t4_ferr_count", 1, ferr_cnt[1] - f0, 1);
      chk("t4_valid_count", 1, valid_cnt[1] - v0, 0);
      chk("t4_data_kept", 1, int'(dat[1]), 8'h42);
      send_frame(1, 8'h7E, 1'b1, P_A, 1'b1);
      #(P_A);
      chk("t4_after_data", 1, int'(dat[1]), 8'h7E);
      chk("t4_after_valid", 1, valid_cnt[1] - v0, 1);

      // Reset during data bit 4; held until the frame has left the line.
      v0 = valid_cnt[1];
      fork
         send_frame(1, 8'hC3, 1'b1, P_A, 1'b0);
         begin
            #(5 * P_A + P_A / 2);
            rstn_v[1] = 1'b0;
            model_reset(1);
            #1;
            chk("t5_rst_valid", 1, int'(vld[1]), 0);
            chk("t5_rst_ferr", 1, int'(fe[1]), 0);
            chk("t5_rst_data", 1, int'(dat[1]), 8'h00);
         end
      join
      #(P_A);
      rstn_v[1] = 1'b1;
      #(P_A);
      chk("t5_no_strobe", 1, valid_cnt[1] - v0, 0);
      send_frame(1, 8'h96, 1'b1, P_A, 1'b1);
      #(P_A);
      chk("t5_data", 1, int'(dat[1]), 8'h96);
      chk("t5_valid_count", 1, valid_cnt[1] - v0, 1);
   endtask

   task automatic seq_c();
      int v0;

      // Bit period skewed +3% then -3%.
      v0 = valid_cnt[2];
      send_frame(2, 8'h5A, 1'b1, P_C + 48, 1'b1);
      send_frame(2, 8'hA5, 1'b1, P_C - 48, 1'b1);
      #(P_C);
      chk("t6_data", 2, int'(dat[2]), 8'hA5);
      chk("t6_valid_count", 2, valid_cnt[2] - v0, 2);

      for (int n = 0; n < 150; n++) begin
         int         r;
         int         per;
         logic [7:0] b;
         r   = int'($urandom_range(0, 9));
         per = 2 * int'($urandom_range(776, 824));
         b   = 8'($urandom);
         if (r == 0) begin
            rx_v[2] = 1'b0;
            #(int'($urandom_range(1, 4)) * CLK_T);
            rx_v[2] = 1'b1;
            #(20 * CLK_T);
         end else if (r == 1) begin
            send_frame(2, b, 1'b0, per, 1'b1);
            #(int'($urandom_range(0, 40)) * CLK_T);
            rx_v[2] = 1'b1;
            #(P_C);
         end else begin
            send_frame(2, b, 1'b1, per, 1'b1);
            if ($urandom_range(0, 2) != 0) #(int'($urandom_range(1, 30)) * CLK_T);
         end
      end
      #(2 * P_C);
   endtask

   initial begin
      #(9_000_000);
      $display("FAIL watchdog: bench did not complete, cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rstn_v[i]          = 1'b0;
         rx_v[i]            = 1'b1;
         qh[i]              = 0;
         qt[i]              = 0;
         last_byte[i]       = 8'h00;
         valid_cnt[i]       = 0;
         ferr_cnt[i]        = 0;
         last_strobe_cyc[i] = 0;
      end
      repeat (3) @(negedge clk);
      #25;
      for (int i = 0; i < 3; i++) begin
         chk("reset_valid", i, int'(vld[i]), 0);
         chk("reset_ferr", i, int'(fe[i]), 0);
         chk("reset_data", i, int'(dat[i]), 8'h00);
      end
      for (int i = 0; i < 3; i++) rstn_v[i] = 1'b1;
      #(P_C);

      fork
         seq_a();
         seq_b();
         seq_c();
      join

      for (int w = 0; w < 2000 && (qh[0] != qt[0] || qh[1] != qt[1] || qh[2] != qt[2]); w++)
         @(negedge clk);
      for (int i = 0; i < 3; i++) chk("queue_drained", i, qt[i] - qh[i], 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
